// File: rtl/univ_shift_reg.sv
// Universal shift register.
// Supports hold, shift right, shift left and parallel load, with optional
// rotation and a saturating count of shifts since the last load or reset.
// Q, cnt and empty are all registered. sout_r and sout_l are taps on Q only.
module univ_shift_reg #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         rot,
    input  logic                         sin_r,
    input  logic                         sin_l,
    input  logic [WIDTH-1:0]             D,
    output logic [WIDTH-1:0]             Q,
    output logic                         sout_r,
    output logic                         sout_l,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         empty
);

    localparam int             CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_next;
    logic             empty_reg;
    logic             empty_next;

    // Candidate next values for each shift direction.
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] shl_val;

    // Build the shift networks bit by bit.
    // In each direction, the end bit takes the serial input, or the wrapped-around
    // bit when rotating.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_shr_top
                assign shr_val[gi] = rot ? q_reg[0] : sin_r;
            end else begin : g_shr_mid
                assign shr_val[gi] = q_reg[gi + 1];
            end
            if (gi == 0) begin : g_shl_bot
                assign shl_val[gi] = rot ? q_reg[WIDTH-1] : sin_l;
            end else begin : g_shl_mid
                assign shl_val[gi] = q_reg[gi - 1];
            end
        end
    endgenerate

    // Select the next state.
    // Every shift advances the count, which saturates at WIDTH. empty is raised
    // on the edge at which the count reaches WIDTH.
    always_comb begin
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        empty_next = empty_reg;
        if (en) begin
            case (mode)
                MODE_SHR, MODE_SHL: begin
                    q_next     = (mode == MODE_SHR) ? shr_val : shl_val;
                    cnt_next   = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
                    empty_next = (cnt_next == CNT_MAX);
                end
                MODE_LOAD: begin
                    q_next     = D;
                    cnt_next   = '0;
                    empty_next = 1'b0;
                end
                MODE_HOLD: begin
                    q_next = q_reg;
                end
                default: begin
                    q_next = q_reg;
                end
            endcase
        end
    end

    // State registers. Reset takes priority over every other operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg     <= RESET_VAL;
            cnt_reg   <= '0;
            empty_reg <= 1'b1;
        end else begin
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            empty_reg <= empty_next;
        end
    end

    assign Q      = q_reg;
    assign cnt    = cnt_reg;
    assign empty  = empty_reg;
    assign sout_r = q_reg[0];
    assign sout_l = q_reg[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg with WIDTH=4 and RESET_VAL=0.
// Expected values are computed by hand.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       rot = 1'b0;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic [3:0] D = 4'b0000;
    logic [3:0] Q;
    logic       sout_r;
    logic       sout_l;
    logic [2:0] cnt;
    logic       empty;

    int errors = 0;
    int checks = 0;

    univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .rot    (rot),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .D      (D),
        .Q      (Q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .cnt    (cnt),
        .empty  (empty)
    );

    always #5 clk = ~clk;

    // Drive one cycle on the falling edge, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic r, input logic e, input logic [1:0] m, input logic ro,
                       input logic sr, input logic sl, input logic [3:0] d);
        @(negedge clk);
        rst = r; en = e; mode = m; rot = ro; sin_r = sr; sin_l = sl; D = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all registered outputs and both taps in one call.
    task automatic chk_all(input string tag, input logic [3:0] eq, input logic [2:0] ec,
                           input logic ee);
        chk({tag, ".Q"}, 64'(Q), 64'(eq));
        chk({tag, ".cnt"}, 64'(cnt), 64'(ec));
        chk({tag, ".empty"}, 64'(empty), 64'(ee));
        chk({tag, ".sout_r"}, 64'(sout_r), 64'(eq[0]));
        chk({tag, ".sout_l"}, 64'(sout_l), 64'(eq[3]));
        $display("t=%0t %s: Q=%b cnt=%0d empty=%b", $time, tag, Q, cnt, empty);
    endtask

    initial begin
        // Reset state.
        cyc(1, 0, 2'b00, 0, 0, 0, 4'b0000); chk_all("reset", 4'b0000, 0, 1);

        // Load 1010, then 4 shift-rights with sin_r=1 and no rotation.
        cyc(0, 1, 2'b11, 0, 0, 0, 4'b1010); chk_all("load1010", 4'b1010, 0, 0);
        cyc(0, 1, 2'b01, 0, 1, 0, 4'b0000); chk_all("shr1", 4'b1101, 1, 0);
        cyc(0, 1, 2'b01, 0, 1, 0, 4'b0000); chk_all("shr2", 4'b1110, 2, 0);
        cyc(0, 1, 2'b01, 0, 1, 0, 4'b0000); chk_all("shr3", 4'b1111, 3, 0);
        cyc(0, 1, 2'b01, 0, 1, 0, 4'b0000); chk_all("shr4", 4'b1111, 4, 1);

        // After saturation, shifts still move Q while cnt and empty hold.
        cyc(0, 1, 2'b01, 0, 0, 0, 4'b0000); chk_all("shr_sat1", 4'b0111, 4, 1);
        cyc(0, 1, 2'b01, 0, 0, 0, 4'b0000); chk_all("shr_sat2", 4'b0011, 4, 1);

        // Load 1001 on the cycle after saturation, then 4 left rotates.
        cyc(0, 1, 2'b11, 0, 0, 0, 4'b1001); chk_all("load1001", 4'b1001, 0, 0);
        cyc(0, 1, 2'b10, 1, 0, 0, 4'b0000); chk_all("rol1", 4'b0011, 1, 0);
        cyc(0, 1, 2'b10, 1, 0, 0, 4'b0000); chk_all("rol2", 4'b0110, 2, 0);
        cyc(0, 1, 2'b10, 1, 0, 0, 4'b0000); chk_all("rol3", 4'b1100, 3, 0);
        cyc(0, 1, 2'b10, 1, 0, 0, 4'b0000); chk_all("rol4", 4'b1001, 4, 1);

        // Load 0101, then hold with en=0 while mode=11 and D=1111.
        cyc(0, 1, 2'b11, 0, 0, 0, 4'b0101); chk_all("load0101", 4'b0101, 0, 0);
        cyc(0, 0, 2'b11, 0, 0, 0, 4'b1111); chk_all("en0_1", 4'b0101, 0, 0);
        cyc(0, 0, 2'b11, 0, 0, 0, 4'b1111); chk_all("en0_2", 4'b0101, 0, 0);
        cyc(0, 0, 2'b11, 0, 0, 0, 4'b1111); chk_all("en0_3", 4'b0101, 0, 0);

        // mode=00 with en=1 holds.
        cyc(0, 1, 2'b00, 1, 1, 1, 4'b1111); chk_all("hold", 4'b0101, 0, 0);

        // Right rotate, then back-to-back mode changes.
        cyc(0, 1, 2'b01, 1, 0, 0, 4'b0000); chk_all("ror1", 4'b1010, 1, 0);
        cyc(0, 1, 2'b11, 0, 0, 0, 4'b1000); chk_all("load1000", 4'b1000, 0, 0);
        cyc(0, 1, 2'b01, 0, 0, 0, 4'b0000); chk_all("mix_shr", 4'b0100, 1, 0);
        cyc(0, 1, 2'b10, 0, 0, 1, 4'b0000); chk_all("mix_shl", 4'b1001, 2, 0);

        // Reset overrides a simultaneous load, then a load on the next cycle.
        cyc(1, 1, 2'b11, 0, 0, 0, 4'b1111); chk_all("rst_load", 4'b0000, 0, 1);
        cyc(0, 1, 2'b11, 0, 0, 0, 4'b1111); chk_all("load1111", 4'b1111, 0, 0);

        // Reset in the middle of a shift sequence.
        cyc(0, 1, 2'b01, 0, 0, 0, 4'b0000); chk_all("pre_rst_shr", 4'b0111, 1, 0);
        cyc(1, 1, 2'b01, 0, 1, 0, 4'b0000); chk_all("rst_shr", 4'b0000, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, register width in bits; legal range 2..64.
REQ-002 The block SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into Q on reset.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 The block SHALL have port en, input, 1 bit, clock enable; when 0, all state holds.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 The block SHALL have port rot, input, 1 bit; when 1, shifts rotate instead of taking serial input.
REQ-008 The block SHALL have port sin_r, input, 1 bit, serial bit entering Q[WIDTH-1] on a shift right.
REQ-009 The block SHALL have port sin_l, input, 1 bit, serial bit entering Q[0] on a shift left.
REQ-010 The block SHALL have port D, input, WIDTH bits, parallel load data.
REQ-011 The block SHALL have port Q, output, WIDTH bits, registered parallel output.
REQ-012 The block SHALL have port sout_r, output, 1 bit, always equal to Q[0].
REQ-013 The block SHALL have port sout_l, output, 1 bit, always equal to Q[WIDTH-1].
REQ-014 The block SHALL have port cnt, output, clog2(WIDTH+1) bits, shifts since last load or reset.
REQ-015 The block SHALL have port empty, output, 1 bit, registered; high when cnt equals WIDTH.

Function
REQ-016 With rst=0, en=1, mode=11, the block SHALL set Q<=D, cnt<=0 and empty<=0 at the edge; latency is 1 cycle.
REQ-017 With rst=0, en=1, mode=01, the block SHALL set Q<={rot ? Q[0] : sin_r, Q[WIDTH-1:1]}.
REQ-018 With rst=0, en=1, mode=10, the block SHALL set Q<={Q[WIDTH-2:0], rot ? Q[WIDTH-1] : sin_l}.
REQ-019 With mode=00, or with en=0 in any mode, the block SHALL leave Q, cnt and empty unchanged.
REQ-020 Each shift (mode 01 or 10, en=1), rotating or not, SHALL increment cnt by 1, saturating at WIDTH; no wrap to 0.
REQ-021 The block SHALL set empty<=1 on the same edge at which cnt becomes WIDTH, and hold it until the next load or reset.
REQ-022 Shifts after saturation SHALL still shift Q, with cnt held at WIDTH and empty held at 1.
REQ-023 A load in the cycle after saturation SHALL clear cnt and empty in that one edge.
REQ-024 sout_r and sout_l SHALL be combinational taps of the Q register only, with no path from any input.
REQ-025 Mode changes between consecutive cycles SHALL take effect immediately, with no idle cycle required.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL set Q<=RESET_VAL, cnt<=0, empty<=1, overriding en and mode.
REQ-027 A reset asserted mid-sequence (during shifts or loads) SHALL discard that cycle's operation and apply REQ-026.
REQ-028 Before the first reset edge, output values SHALL be undefined; the bench SHALL assert rst for at least 1 cycle first.

Verification (WIDTH=4, RESET_VAL=0)
REQ-029 The bench SHALL cover: rst=1 for one edge -> Q=0000, cnt=0, empty=1, sout_r=0, sout_l=0.
REQ-030 The bench SHALL cover: load D=1010, then 4 shift-rights with sin_r=1, rot=0 -> Q=1101, 1110, 1111, 1111; cnt=1,2,3,4; empty=1 only after the 4th.
REQ-031 The bench SHALL cover: load 1001, then 4 shift-lefts with rot=1 -> Q=0011, 0110, 1100, 1001; empty=1 after the 4th.
REQ-032 The bench SHALL cover: load 0101, then en=0 with mode=11, D=1111 for 3 cycles -> Q stays 0101 and cnt stays 0.
REQ-033 The bench SHALL cover: rst=1 together with mode=11, D=1111 -> Q=0000, cnt=0, empty=1; the next-cycle load 1111 gives Q=1111, empty=0.
REQ-034 The bench SHALL cover: after saturation, 2 further shift-rights with sin_r=0 -> cnt stays 4, Q shifts; then one load -> cnt=0, empty=0.
